data_memory_hs: RTL and testbench

//  Clocked, handshaked successor of the combinational data memory in the MEM stage.

---
 rtl/data_memory_hs.sv | 165 ++++++++++++++++
 tb/tb_data_memory_hs.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_hs.sv
// data_memory_hs: clocked, handshaked byte-addressed big-endian data memory (lb/lh/lw/lbu/lhu, sb/sh/sw); define DMEM_ERR_EN to enable Err.
// Latency: accept at edge N, access at edge N+1+WAIT_STATES, Done high for the following cycle.
// Backpressure: Ready only while idle; requests are ignored while busy, giving one access per WAIT_STATES+3 cycles.
module data_memory_hs #(
  parameter int DEPTH_BYTES = 2048,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Req,
  input  logic [31:0] Address,
  input  logic [31:0] DataWr,
  input  logic        DMWr,
  input  logic [2:0]  DMCtrl,
  output logic        Ready,
  output logic        Done,
  output logic [31:0] DataRd,
  output logic        Err
);
  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    wait_cnt;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          wr_q;
  logic [2:0]    ctrl_q;
  logic          ready_c;
  logic          done_c;
  logic [1:0]    size;
  logic          legal;
  logic          reject;
  logic          access_fire;
  logic [AW-1:0] idx [4];
  logic [7:0]    rd_b [4];
  logic [31:0]   ld_val;

  logic [7:0]    mem [DEPTH_BYTES] = '{default: 8'h00};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    done_c    = 1'b0;
    case (state)
      S_IDLE: begin
        ready_c = 1'b1;
        if (Req) state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
      end
      S_WAIT: begin
        if (wait_cnt == 4'(WAIT_STATES - 1)) state_nxt = S_ACCESS;
      end
      S_ACCESS: state_nxt = S_DONE;
      S_DONE: begin
        done_c    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign Ready = ready_c;
  assign Done  = done_c;

  always_ff @(posedge clk) begin
    if (rst)                   wait_cnt <= '0;
    else if (state == S_WAIT)  wait_cnt <= wait_cnt + 4'd1;
    else                       wait_cnt <= '0;
  end

  // Request fields are captured once at accept; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      ctrl_q  <= '0;
    end else if (state == S_IDLE && Req) begin
      addr_q  <= Address;
      wdata_q <= DataWr;
      wr_q    <= DMWr;
      ctrl_q  <= DMCtrl;
    end
  end

  assign size  = ctrl_q[1:0];
  assign legal = (ctrl_q == 3'b000) || (ctrl_q == 3'b001) || (ctrl_q == 3'b010) ||
                 (ctrl_q == 3'b100) || (ctrl_q == 3'b101);

`ifdef DMEM_ERR_EN
  logic misalign;
  logic range_err;
  logic err_q;

  assign misalign  = ((size == 2'b10) && (addr_q[1:0] != 2'b00)) ||
                     ((size == 2'b01) && addr_q[0]);
  // All access sizes touch lane A+3, so the range check is size-independent.
  assign range_err = (({1'b0, addr_q} + 33'd3) >= 33'(DEPTH_BYTES));
  assign reject    = !legal || misalign || range_err;

  always_ff @(posedge clk) begin
    if (rst)                     err_q <= 1'b0;
    else if (state == S_ACCESS)  err_q <= reject;
  end

  assign Err = done_c & err_q;
`else
  logic unused_addr_hi;

  assign reject         = !legal;
  assign unused_addr_hi = ^addr_q[31:AW];
  assign Err            = 1'b0;
`endif

  // Byte lanes wrap modulo the depth; with error checking on, rejects keep them in range.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      idx[k]  = addr_q[AW-1:0] + AW'(k);
      rd_b[k] = mem[idx[k]];
    end
  end

  always_comb begin
    ld_val = {rd_b[0], rd_b[1], rd_b[2], rd_b[3]};
    case (size)
      2'b00:   ld_val = ctrl_q[2] ? {24'h0, rd_b[3]} : {{24{rd_b[3][7]}}, rd_b[3]};
      2'b01:   ld_val = ctrl_q[2] ? {16'h0, rd_b[2], rd_b[3]}
                                  : {{16{rd_b[2][7]}}, rd_b[2], rd_b[3]};
      default: ld_val = {rd_b[0], rd_b[1], rd_b[2], rd_b[3]};
    endcase
  end

  // A reset on the access edge suppresses the write.
  assign access_fire = (state == S_ACCESS) && !rst;

  always_ff @(posedge clk) begin
    if (access_fire && wr_q && !reject) begin
      case (size)
        2'b10: begin
          mem[idx[0]] <= wdata_q[31:24];
          mem[idx[1]] <= wdata_q[23:16];
          mem[idx[2]] <= wdata_q[15:8];
          mem[idx[3]] <= wdata_q[7:0];
        end
        2'b01: begin
          mem[idx[2]] <= wdata_q[15:8];
          mem[idx[3]] <= wdata_q[7:0];
        end
        default: mem[idx[3]] <= wdata_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                         DataRd <= '0;
    else if (state == S_ACCESS && !wr_q && !reject)  DataRd <= ld_val;
  end

endmodule

// File: tb/tb_data_memory_hs.sv
// Bench for data_memory_hs: directed and random accesses, scoreboard against a byte-array memory model.
`timescale 1ns/1ps
module tb_data_memory_hs;
  localparam int DEPTH = 2048;
  localparam int WS    = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        Req;
  logic [31:0] Address;
  logic [31:0] DataWr;
  logic        DMWr;
  logic [2:0]  DMCtrl;
  logic        Ready;
  logic        Done;
  logic [31:0] DataRd;
  logic        Err;

  always #5 clk = ~clk;

  data_memory_hs #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .Req(Req), .Address(Address), .DataWr(DataWr),
    .DMWr(DMWr), .DMCtrl(DMCtrl), .Ready(Ready), .Done(Done), .DataRd(DataRd), .Err(Err)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  ref_mem [DEPTH];
  logic [31:0] ref_rd;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          last_acc = 0;
  bit          b2b = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int unsigned ix(logic [31:0] a, int k);
    return (a + 32'(k)) % 32'(DEPTH);
  endfunction

  // Memory seen as the big-endian word at A; narrower accesses use its low end.
  function automatic exp_t model(logic wr, logic [2:0] ctrl, logic [31:0] a, logic [31:0] d, int acc);
    exp_t        e;
    bit          rej;
    logic [31:0] w;
    rej = !(ctrl inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef DMEM_ERR_EN
    if (ctrl == 3'b010 && a[1:0] != 2'b00) rej = 1'b1;
    if ((ctrl == 3'b001 || ctrl == 3'b101) && a[0]) rej = 1'b1;
    if (({32'h0, a} + 64'd3) >= 64'(DEPTH)) rej = 1'b1;
    e.err = rej;
`else
    e.err = 1'b0;
`endif
    if (!rej) begin
      if (wr) begin
        case (ctrl[1:0])
          2'b10: for (int k = 0; k < 4; k++) ref_mem[ix(a, k)] = d[31-8*k -: 8];
          2'b01: begin
            ref_mem[ix(a, 2)] = d[15:8];
            ref_mem[ix(a, 3)] = d[7:0];
          end
          default: ref_mem[ix(a, 3)] = d[7:0];
        endcase
      end else begin
        w = {ref_mem[ix(a, 0)], ref_mem[ix(a, 1)], ref_mem[ix(a, 2)], ref_mem[ix(a, 3)]};
        case (ctrl[1:0])
          2'b00:   ref_rd = ctrl[2] ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
          2'b01:   ref_rd = ctrl[2] ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
          default: ref_rd = w;
        endcase
      end
    end
    e.data = ref_rd;
    e.acc  = acc;
    return e;
  endfunction

  // Keeps Req high with junk inputs while busy; returns at the first negedge with Ready.
  task automatic wait_ready(output bit ok);
    int guard;
    guard = 0;
    ok = 1'b1;
    @(negedge clk);
    while (Ready !== 1'b1) begin
      Req     = 1'b1;
      Address = $urandom;
      DataWr  = $urandom;
      DMWr    = 1'($urandom_range(0, 1));
      DMCtrl  = 3'($urandom_range(0, 7));
      guard++;
      if (guard > 64) begin
        n_tests++;
        n_fail++;
        $display("FAIL ready_timeout: Ready still %b after %0d cycles, want 1", Ready, guard);
        ok = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic issue(logic wr, logic [2:0] ctrl, logic [31:0] a, logic [31:0] d);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    Req = 1'b1; Address = a; DataWr = d; DMWr = wr; DMCtrl = ctrl;
    if (b2b) check("throughput", 32'(cyc + 1 - last_acc), 32'(WS + 3));
    last_acc = cyc + 1;
    b2b = 1'b1;
    sb_q.push_back(model(wr, ctrl, a, d, cyc + 1));
    @(posedge clk);
  endtask

  task automatic abort_store(logic [31:0] a, logic [31:0] d);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    Req = 1'b1; Address = a; DataWr = d; DMWr = 1'b1; DMCtrl = 3'b010;
    @(posedge clk);
    @(negedge clk);
    Req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_rd = '0;
    b2b = 1'b0;
    check("ready_after_rst", {31'b0, Ready}, 32'd1);
    check("datard_after_rst", DataRd, 32'h0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (Done === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: Done=1 with no outstanding access, want 0");
        end else begin
          e = sb_q.pop_front();
          check("datard", DataRd, e.data);
          check("err", {31'b0, Err}, {31'b0, e.err});
          check("latency", 32'(cyc - e.acc), 32'(WS + 1));
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] a;
    int          g;
    rst = 1'b1; Req = 1'b0; Address = '0; DataWr = '0; DMWr = 1'b0; DMCtrl = '0;
    ref_rd = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;

    repeat (2) @(negedge clk);
    check("rst_ready",  {31'b0, Ready}, 32'd1);
    check("rst_done",   {31'b0, Done},  32'd0);
    check("rst_datard", DataRd,         32'h0);
    check("rst_err",    {31'b0, Err},   32'd0);
    rst = 1'b0;

    issue(1'b0, 3'b010, 32'h0,   32'h0);
    issue(1'b1, 3'b010, 32'h10,  32'h8899AABB);
    issue(1'b0, 3'b010, 32'h10,  32'h0);
    issue(1'b0, 3'b000, 32'h10,  32'h0);
    issue(1'b0, 3'b100, 32'h10,  32'h0);
    issue(1'b0, 3'b001, 32'h10,  32'h0);
    issue(1'b0, 3'b101, 32'h10,  32'h0);
    issue(1'b1, 3'b000, 32'h10,  32'h11);
    issue(1'b0, 3'b010, 32'h10,  32'h0);

    abort_store(32'h20, 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h20,  32'h0);

    issue(1'b1, 3'b010, 32'h24,  32'h01234567);
    issue(1'b0, 3'b010, 32'h22,  32'h0);
    issue(1'b1, 3'b010, 32'h7FE, 32'hCAFEF00D);
    issue(1'b0, 3'b000, 32'h7FC, 32'h0);
    issue(1'b0, 3'b010, 32'h0,   32'h0);
    issue(1'b1, 3'b011, 32'h30,  32'h55667788);
    issue(1'b0, 3'b010, 32'h30,  32'h0);
    issue(1'b0, 3'b111, 32'h30,  32'h0);

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       a = $urandom;
        1:       a = 32'($urandom_range(DEPTH - 8, DEPTH + 4));
        default: a = 32'($urandom_range(0, 63));
      endcase
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        Req = 1'b0;
        repeat ($urandom_range(1, 8)) @(negedge clk);
        b2b = 1'b0;
      end
    end

    @(negedge clk);
    Req = 1'b0;
    g = 0;
    while (sb_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d accesses never completed, want 0", sb_q.size());
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
